// File: rtl/debounce_pkg.sv
// Shared types for the debounce scan controller: FSM states, queued event layout
// and the channel-index width helper.
package debounce_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Event channel field is sized for the largest supported bank (256 channels);
    // the top narrows it to the real index width at its ports.
    localparam int EVT_CHN_W = 8;

    typedef struct packed {
        logic [EVT_CHN_W-1:0] chn;
        logic                 lvl;
    } evt_t;

    function automatic int chn_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/debounce_evt_fifo.sv
// Small synchronous FIFO for debounce events. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped and flagged.
module debounce_evt_fifo #(
    parameter int W  = 9,
    parameter int QD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         drop
);
    localparam int AW = $clog2(QD);

    logic [W-1:0] mem [QD];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign drop  = push && full && !rd_en;
    // Head is read combinationally so it is valid in the same cycle as evt_vld.
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debouncer bank: one shared counter-update datapath visits one
// channel per clock after each prescaler tick; level changes are queued as events.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int CH  = 8,
    parameter int CN  = 8,
    parameter int CW  = $clog2(CN + 1),
    parameter int PRE = 64,
    parameter int QD  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH-1:0]            d_i,
    input  logic [CH-1:0]            en_i,
    output logic [CH-1:0]            d_o,
    output logic                     evt_vld,
    input  logic                     evt_rdy,
    output logic [chn_width(CH)-1:0] evt_chn,
    output logic                     evt_lvl,
    output logic                     ovf_o,
    input  logic                     ovf_clr
);
    localparam int CHW = chn_width(CH);
    localparam int PW  = $clog2(PRE);

    logic [CH-1:0]  ds_meta;
    logic [CH-1:0]  ds;
    logic [PW-1:0]  pre_cnt;
    logic           tick;
    state_t         state, state_next;
    logic [CHW-1:0] idx, idx_next;
    logic           upd;
    logic [CW-1:0]  cnt_mem [CH];
    logic [CW-1:0]  cnt_cur;
    logic [CW-1:0]  cnt_new;
    logic           lvl_new;
    logic           evt_push;
    logic           evt_pop;
    evt_t           evt_in;
    evt_t           evt_head;
    logic           fifo_empty;
    logic           fifo_full;
    logic           fifo_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_meta <= '0;
            ds      <= '0;
        end else begin
            ds_meta <= d_i;
            ds      <= ds_meta;
        end
    end

    assign tick = (pre_cnt == PW'(PRE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            state   <= IDLE;
            idx     <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            state   <= state_next;
            idx     <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        upd        = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = SCAN;
                    idx_next   = '0;
                end
            end
            SCAN: begin
                upd = 1'b1;
                if (idx == CHW'(CH - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shared update datapath for the channel currently in its slot.
    always_comb begin
        cnt_cur = cnt_mem[idx];
        cnt_new = cnt_cur;
        if (!en_i[idx])
            cnt_new = '0;
        else if (ds[idx])
            cnt_new = CW'(CN);
        else if (cnt_cur != '0)
            cnt_new = cnt_cur - 1'b1;
    end

    assign lvl_new  = (cnt_new != '0);
    // A disabled channel still gets forced low, but only enabled channels report.
    assign evt_push = upd && en_i[idx] && (lvl_new != d_o[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) cnt_mem[i] <= '0;
            d_o <= '0;
        end else if (upd) begin
            cnt_mem[idx] <= cnt_new;
            d_o[idx]     <= lvl_new;
        end
    end

    always_comb begin
        evt_in     = '0;
        evt_in.chn = EVT_CHN_W'(idx);
        evt_in.lvl = lvl_new;
    end

    assign evt_pop = evt_vld && evt_rdy;

    debounce_evt_fifo #(
        .W  ($bits(evt_t)),
        .QD (QD)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (evt_push),
        .din   (evt_in),
        .pop   (evt_pop),
        .dout  (evt_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

    assign evt_vld = !fifo_empty;
    assign evt_chn = CHW'(evt_head.chn);
    assign evt_lvl = evt_head.lvl;

    // A new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_o <= 1'b0;
        else if (fifo_drop)
            ovf_o <= 1'b1;
        else if (ovf_clr)
            ovf_o <= 1'b0;
    end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl with an event scoreboard: expected events
// are queued when stimulus is applied and matched as the DUT hands them out.
module tb_debounce_scan_ctrl;
    localparam int CH  = 4;
    localparam int CN  = 3;
    localparam int PRE = 8;
    localparam int QD  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] d_i = '0;
    logic [CH-1:0] en_i = '0;
    logic [CH-1:0] d_o;
    logic          evt_vld;
    logic          evt_rdy = 1'b0;
    logic [1:0]    evt_chn;
    logic          evt_lvl;
    logic          ovf_o;
    logic          ovf_clr = 1'b0;

    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rel = 0;
    int         n;
    logic [2:0] sb [$];
    logic [2:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_scan_ctrl #(.CH(CH), .CN(CN), .PRE(PRE), .QD(QD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (d_i),
        .en_i    (en_i),
        .d_o     (d_o),
        .evt_vld (evt_vld),
        .evt_rdy (evt_rdy),
        .evt_chn (evt_chn),
        .evt_lvl (evt_lvl),
        .ovf_o   (ovf_o),
        .ovf_clr (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && evt_vld && evt_rdy) begin
            mon_exp = (sb.size() != 0) ? sb.pop_front() : 3'bxxx;
            chk("evt", {29'd0, evt_chn, evt_lvl}, {29'd0, mon_exp});
            $display("event chn=%0d lvl=%0d", evt_chn, evt_lvl);
        end
    end

    // Returns just after the edge that leaves the prescaler at phase ph.
    task automatic align(input int ph);
        do begin
            @(posedge clk);
            #1;
        end while (((cyc - rel) % PRE) != ph);
    endtask

    task automatic wait_lvl(input int ch, input logic lvl, input int maxc, output int cnt);
        cnt = 0;
        while (cnt < maxc) begin
            @(negedge clk);
            cnt++;
            if (d_o[ch] === lvl) return;
        end
        cnt = maxc + 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", d_o, 0);
        chk("rst_vld", evt_vld, 0);
        chk("rst_ovf", ovf_o, 0);
        en_i    = '1;
        evt_rdy = 1'b1;
        rst_n   = 1'b1;
        rel     = cyc;

        // Rise on ch1: slot for ch1 is 7 clocks after the phase-4 edge.
        align(4);
        d_i[1] = 1'b1;
        sb.push_back({2'd1, 1'b1});
        wait_lvl(1, 1'b1, 20, n);
        chk("rise_lat", n, 7);
        chk("rise_dout", d_o, 4'b0010);
        repeat (PRE) @(negedge clk);
        chk("rise_hold", d_o, 4'b0010);
        chk("rise_sb", sb.size(), 0);

        // Last high sample is the ch1 slot 2 clocks before release; fall 3 ticks later.
        align(4);
        d_i[1] = 1'b0;
        sb.push_back({2'd1, 1'b0});
        wait_lvl(1, 1'b0, 40, n);
        chk("fall_lat", n, 23);
        @(negedge clk);
        chk("fall_dout", d_o, 4'b0000);
        chk("fall_sb", sb.size(), 0);

        // One-clock pulse on ch2 reaches the synchronized input only at phase 5.
        align(3);
        d_i[2] = 1'b1;
        @(posedge clk);
        #1;
        d_i[2] = 1'b0;
        repeat (4 * PRE) @(negedge clk);
        chk("glitch_dout", d_o, 4'b0000);
        chk("glitch_vld", evt_vld, 0);

        // Three simultaneous rises into a two-deep queue: ch3 is dropped.
        evt_rdy = 1'b0;
        align(4);
        d_i = 4'b1011;
        sb.push_back({2'd0, 1'b1});
        sb.push_back({2'd1, 1'b1});
        n = 0;
        while (n < 20 && ovf_o !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_set", ovf_o, 1);
        chk("ovf_head", {evt_chn, evt_lvl}, 3'b001);
        repeat (3) @(negedge clk);
        chk("ovf_head_hold", {evt_chn, evt_lvl}, 3'b001);
        chk("ovf_dout", d_o, 4'b1011);
        @(posedge clk);
        #1;
        evt_rdy = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovf_drain_sb", sb.size(), 0);
        chk("ovf_drain_vld", evt_vld, 0);
        chk("ovf_sticky", ovf_o, 1);
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf_o, 0);

        // Disabling ch0/ch1 forces them low without events.
        en_i = 4'b1100;
        repeat (2 * PRE) @(negedge clk);
        chk("dis_dout", d_o, 4'b1000);
        chk("dis_vld", evt_vld, 0);

        // Re-enable, let two events sit in the queue, then reset mid-scan at idx=2.
        evt_rdy = 1'b0;
        en_i    = 4'b1111;
        sb.push_back({2'd0, 1'b1});
        sb.push_back({2'd1, 1'b1});
        repeat (2 * PRE) @(negedge clk);
        chk("pre_rst_vld", evt_vld, 1);
        chk("pre_rst_dout", d_o, 4'b1011);
        align(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", d_o, 4'b0000);
        chk("mid_rst_vld", evt_vld, 0);
        chk("mid_rst_ovf", ovf_o, 0);
        sb.delete();
        d_i = '0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        evt_rdy = 1'b1;
        repeat (3 * PRE) @(negedge clk);
        chk("post_rst_vld", evt_vld, 0);
        chk("post_rst_dout", d_o, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
